// File: rtl/gray_code_conv_pkg.sv
// Shared types and helpers for the binary/Gray converter.
// The helpers work on 32-bit words and mask the result to the active width.
package gray_code_pkg;

  localparam int GC_MAX_WIDTH = 32;

  typedef enum logic {
    MON_EMPTY,
    MON_PRIMED
  } mon_state_t;

  function automatic logic [GC_MAX_WIDTH-1:0] width_mask(input int unsigned width);
    if (width >= GC_MAX_WIDTH) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic logic [GC_MAX_WIDTH-1:0] bin2gray(input logic [GC_MAX_WIDTH-1:0] bin,
                                                       input int unsigned width);
    logic [GC_MAX_WIDTH-1:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; bits above the active width are zero, so
  // starting at the top of the 32-bit word gives the same result.
  function automatic logic [GC_MAX_WIDTH-1:0] gray2bin(input logic [GC_MAX_WIDTH-1:0] gray,
                                                       input int unsigned width);
    logic [GC_MAX_WIDTH-1:0] g;
    logic [GC_MAX_WIDTH-1:0] b;
    g = gray & width_mask(width);
    b = '0;
    b[GC_MAX_WIDTH-1] = g[GC_MAX_WIDTH-1];
    for (int i = GC_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [GC_MAX_WIDTH-1:0] v);
    logic [5:0] count;
    count = '0;
    for (int i = 0; i < GC_MAX_WIDTH; i++) begin
      count = count + 6'(v[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/gray_code_conv_if.sv
// Data/valid bundle between a stimulus source and the Gray converter.
interface gray_code_conv_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] binary_value;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] gray_value;
  logic [WIDTH-1:0] binary_out;
  logic             out_valid;
  logic             step_err;

  modport master (
    output in_valid, binary_value, gray_in,
    input  gray_value, binary_out, out_valid, step_err
  );

  modport slave (
    input  in_valid, binary_value, gray_in,
    output gray_value, binary_out, out_valid, step_err
  );
endinterface

// File: rtl/gray_step_monitor.sv
// Flags successive valid Gray samples that differ in more than one bit.
// The first sample after reset only primes the history.
module gray_step_monitor
  import gray_code_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_gray,
  output logic             step_err
);

  mon_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_gray;
  logic             err_d;
  logic [5:0]       distance;

  assign distance = popcount(GC_MAX_WIDTH'(sample_gray ^ prev_gray));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MON_EMPTY;
      prev_gray <= '0;
      step_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_err <= err_d;
      if (sample_valid) prev_gray <= sample_gray;
    end
  end

  // A repeated value (distance 0) is legal; only multi-bit jumps flag.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (sample_valid) begin
      state_d = MON_PRIMED;
      if (state_q == MON_PRIMED && distance > 6'd1) err_d = 1'b1;
    end
  end

endmodule

// File: rtl/gray_code_conv.sv
// Registered binary-to-Gray encoder and Gray-to-binary decoder, one cycle of
// latency each, with an adjacency monitor on the encoded stream.
module gray_code_conv
  import gray_code_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  gray_code_conv_if.slave  bus
);

  logic [GC_MAX_WIDTH-1:0] gray_full;
  logic [GC_MAX_WIDTH-1:0] bin_full;
  logic [WIDTH-1:0]        gray_next;
  logic [WIDTH-1:0]        bin_next;
  logic [WIDTH-1:0]        gray_q;
  logic [WIDTH-1:0]        bin_q;
  logic                    valid_q;
  logic                    unused_upper;

  assign gray_full = bin2gray(GC_MAX_WIDTH'(bus.binary_value), WIDTH);
  assign bin_full  = gray2bin(GC_MAX_WIDTH'(bus.gray_in), WIDTH);
  assign gray_next = gray_full[WIDTH-1:0];
  assign bin_next  = bin_full[WIDTH-1:0];
  // The helpers mask above WIDTH, so the upper word bits are always zero.
  assign unused_upper = &{1'b0, gray_full, bin_full};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_q  <= '0;
      bin_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        gray_q <= gray_next;
        bin_q  <= bin_next;
      end
    end
  end

  gray_step_monitor #(
    .WIDTH (WIDTH)
  ) u_step_monitor (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (bus.in_valid),
    .sample_gray  (gray_next),
    .step_err     (bus.step_err)
  );

  assign bus.gray_value = gray_q;
  assign bus.binary_out = bin_q;
  assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_gray_code_conv.sv
// Scoreboard bench for gray_code_conv at WIDTH=4: expected outputs are pushed
// when stimulus is driven and popped one cycle later against the DUT.
module tb_gray_code_conv;

  localparam int WIDTH = 4;

  typedef struct {
    string      tag;
    logic [3:0] gray;
    logic [3:0] bin;
    logic       valid;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_code_conv_if #(.WIDTH(WIDTH)) bus_if();

  gray_code_conv #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] m_gray, m_bin, m_prev;
  logic       m_have;

  logic [3:0] sweep_tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  // Decode as XOR of all right shifts of the Gray word.
  function automatic logic [3:0] modelDecode(input logic [3:0] g);
    logic [3:0] b;
    b = g;
    for (int k = 1; k < WIDTH; k++) b = b ^ (g >> k);
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rstn_v, input logic valid_v,
                               input logic [3:0] bin_v, input logic [3:0] gin_v);
    exp_t       e;
    exp_t       got;
    logic [3:0] ng;
    rst_n               = rstn_v;
    bus_if.in_valid     = valid_v;
    bus_if.binary_value = bin_v;
    bus_if.gray_in      = gin_v;
    e.err   = 1'b0;
    e.valid = 1'b0;
    if (!rstn_v) begin
      m_gray = '0;
      m_bin  = '0;
      m_prev = '0;
      m_have = 1'b0;
    end else begin
      e.valid = valid_v;
      if (valid_v) begin
        ng     = bin_v ^ (bin_v >> 1);
        e.err  = m_have && ($countones(ng ^ m_prev) > 1);
        m_gray = ng;
        m_bin  = modelDecode(gin_v);
        m_prev = ng;
        m_have = 1'b1;
      end
    end
    e.gray = m_gray;
    e.bin  = m_bin;
    e.tag  = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checkOutput({got.tag, ".gray"},  32'(bus_if.gray_value), 32'(got.gray));
    checkOutput({got.tag, ".bin"},   32'(bus_if.binary_out), 32'(got.bin));
    checkOutput({got.tag, ".valid"}, 32'(bus_if.out_valid),  32'(got.valid));
    checkOutput({got.tag, ".err"},   32'(bus_if.step_err),   32'(got.err));
  endtask

  initial begin
    logic [3:0] rb;
    logic       rv;

    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b0, 1'b1, 4'hF, 4'hF);
    checkOutput("reset_gray_zero", 32'(bus_if.gray_value), 32'h0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus("sweep", 1'b1, 1'b1, 4'(i), 4'h0);
      checkOutput("sweep_table", 32'(bus_if.gray_value), 32'(sweep_tbl[i]));
    end

    applyStimulus("wrap15", 1'b1, 1'b1, 4'd15, 4'h0);
    checkOutput("wrap15_gray", 32'(bus_if.gray_value), 32'b1000);
    applyStimulus("wrap0", 1'b1, 1'b1, 4'd0, 4'h0);
    checkOutput("wrap0_gray", 32'(bus_if.gray_value), 32'b0000);
    checkOutput("wrap0_err", 32'(bus_if.step_err), 32'd0);

    applyStimulus("dec1011", 1'b1, 1'b1, 4'd0, 4'b1011);
    checkOutput("dec1011_const", 32'(bus_if.binary_out), 32'b1101);
    applyStimulus("dec1000", 1'b1, 1'b1, 4'd0, 4'b1000);
    checkOutput("dec1000_const", 32'(bus_if.binary_out), 32'b1111);
    applyStimulus("dec0110", 1'b1, 1'b1, 4'd0, 4'b0110);
    checkOutput("dec0110_const", 32'(bus_if.binary_out), 32'b0100);

    applyStimulus("step0", 1'b1, 1'b1, 4'd0, 4'h0);
    applyStimulus("step3", 1'b1, 1'b1, 4'd3, 4'h0);
    checkOutput("step3_gray", 32'(bus_if.gray_value), 32'b0010);
    applyStimulus("step5", 1'b1, 1'b1, 4'd5, 4'h0);
    checkOutput("step5_gray", 32'(bus_if.gray_value), 32'b0111);
    checkOutput("step5_err_const", 32'(bus_if.step_err), 32'd1);

    applyStimulus("hold6", 1'b1, 1'b1, 4'd6, 4'h0);
    checkOutput("hold6_err_pulse_end", 32'(bus_if.step_err), 32'd0);
    applyStimulus("gap1", 1'b1, 1'b0, 4'd9, 4'h3);
    checkOutput("gap1_hold", 32'(bus_if.gray_value), 32'b0101);
    applyStimulus("gap2", 1'b1, 1'b0, 4'd12, 4'h5);
    applyStimulus("hold7", 1'b1, 1'b1, 4'd7, 4'h0);
    checkOutput("hold7_gray", 32'(bus_if.gray_value), 32'b0100);

    applyStimulus("midreset", 1'b0, 1'b1, 4'd2, 4'h0);
    applyStimulus("first_after_reset", 1'b1, 1'b1, 4'd5, 4'h0);
    checkOutput("first_after_reset_noflag", 32'(bus_if.step_err), 32'd0);
    applyStimulus("jump_after_reset", 1'b1, 1'b1, 4'd10, 4'h0);

    for (int i = 0; i < 24; i++) begin
      rb = 4'($urandom_range(0, 15));
      rv = 1'($urandom_range(0, 3) != 0);
      applyStimulus("random", 1'b1, rv, rb, rb ^ (rb >> 1));
      if (rv) checkOutput("roundtrip", 32'(bus_if.binary_out), 32'(rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
